arm_id_ctrl_stage: RTL
======================

Name: arm_id_ctrl_stage

Overview:
- Decode-plus-register stage that replaces the purely combinational control decoder in the ARM pipeline.
- It decodes mode, opcode and S into the control word, and evaluates the ARM condition field against the NZCV flags.
- It squashes a configurable number of branch-shadow instructions.
- It registers the result into the ID/EX boundary with stall/flush handling and a saturating squash counter.
- Sits between the register-file read in ID and the EX stage.

Parameters:
- PC_W, 32: width of the passed-through PC.
- BRANCH_SHADOW, 2: valid instructions squashed after an issued branch; 0 disables squashing.
- CNT_W, 16: width of the saturating squash counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- valid_in  in  1  ID holds a real instruction.
- cond  in  4  instruction condition field.
- mode  in  2  instruction type: 00 data-processing, 01 memory, 10 branch, 11 illegal.
- op_code  in  4  data-processing opcode.
- s  in  1  S bit; for memory instructions 1 = LDR, 0 = STR.
- nzcv  in  4  current status flags {N,Z,C,V}.
- pc_in  in  PC_W  PC of the ID instruction.
- stall  in  1  hold the ID/EX register.
- flush  in  1  insert a bubble and clear the shadow.
- valid_out  out  1  EX holds an issued instruction.
- wb_en_out  out  1  registered write-back enable.
- mem_read_out  out  1  registered memory-read enable.
- mem_write_out  out  1  registered memory-write enable.
- exe_cmd_out  out  4  registered execute command.
- b_out  out  1  registered branch flag.
- s_out  out  1  registered status-update flag.
- pc_out  out  PC_W  registered PC.
- illegal_out  out  1  one-cycle pulse: an illegal encoding was squashed.
- squash_cnt  out  CNT_W  count of squashed valid instructions.

Behaviour:
- Reset: all outputs 0, shadow counter 0; asynchronous on rst rising, held while rst=1.
- Decode, combinational, mode 00 (op → wb, exe_cmd):
  - MOV 1101 → 1, 0001
  - MVN 1111 → 1, 1001
  - ADD 0100 → 1, 0010
  - ADC 0101 → 1, 0011
  - SUB 0010 → 1, 0100
  - SBC 0110 → 1, 0101
  - AND 0000 → 1, 0110
  - ORR 1100 → 1, 0111
  - EOR 0001 → 1, 1000
  - CMP 1010 → 0, 0100
  - TST 1000 → 0, 0110
  - status = s for all of the above.
  - Any other opcode is illegal.
- Decode, mode 01: exe_cmd 0010, status 0; s=1 → wb=1, mem_read=1; s=0 → mem_write=1.
- Decode, mode 10: b=1, all else 0.
- Decode, mode 11: illegal.
- Condition pass:
  - EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V.
  - HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V).
  - AL 1; 1111 = never (fails).
- Squash conditions (any of):
  - valid_in=0
  - condition fails
  - shadow counter ≠ 0
  - illegal encoding
- A squashed instruction loads a bubble: every control output 0, valid_out 0, pc_out still loads pc_in.
- Register update, priority order:
  - flush: bubble loaded, shadow counter cleared, illegal_out 0, squash_cnt unchanged.
  - else stall: all outputs and shadow counter hold; illegal_out forced 0.
  - else: ID/EX register loads the decoded word or a bubble.
- Latency: one cycle from ID inputs to registered outputs.
- Shadow:
  - An issued branch (b=1, not squashed, not stalled) loads the counter with BRANCH_SHADOW.
  - Each subsequent non-stalled cycle with valid_in=1 decrements the counter and squashes that instruction.
  - Cycles with valid_in=0 do not decrement.
  - A branch arriving inside the shadow is squashed and does not reload the counter.
- illegal_out: 1 for exactly the cycle after a non-stalled, non-flushed, valid, condition-passing illegal encoding; otherwise 0.
- squash_cnt: increments when a non-stalled, non-flushed valid_in=1 instruction is squashed for any reason; saturates at 2^CNT_W−1, never wraps.
- Simultaneous events:
  - flush+stall → flush wins.
  - Branch in ID with flush → not issued, counter cleared.

Test Plan:
- rst=1 mid-stream after ADD issued → all outputs 0 immediately (before the next edge); after release, idle stays valid_out=0.
- valid_in=1, mode=00, op=0100, s=1, cond=1110 → next cycle valid_out=1, wb=1, exe_cmd=0010, s_out=1; same with cond=0000, nzcv=0000 → bubble, squash_cnt=1.
- mode=01, s=1 then s=0 → {wb, mem_read, mem_write, exe_cmd} = 1,1,0,0010 then 0,0,1,0010; stall=1 for 3 cycles → outputs frozen.
- BRANCH_SHADOW=2: branch, then ADD, a valid_in=0 idle cycle, SUB, ORR → branch issues, ADD and SUB squashed, ORR issues with exe_cmd=0111; squash_cnt=2.
- mode=11 valid → illegal_out pulse of exactly 1 cycle, valid_out=0; op=0011 in mode 00 → same.
- CNT_W=2: five squashed instructions → squash_cnt sticks at 3; flush during an active shadow → next ADD issues normally.

Source files
------------

// File: rtl/arm_id_ctrl_stage.sv
// ID/EX control stage for the ARM pipeline: decodes mode/opcode/S,
// checks the condition field against NZCV, squashes branch shadows and
// registers the control word across the ID/EX boundary.
//
// Ports:
//   clk, rst          rising-edge clock, async active-high reset
//   valid_in          ID holds a real instruction
//   cond, mode        condition field, instruction type
//   op_code, s        DP opcode, S bit (LDR/STR select for memory)
//   nzcv              current status flags {N,Z,C,V}
//   pc_in             PC of the ID instruction
//   stall, flush      hold the register / insert a bubble
//   valid_out ..      registered control word and PC
//   illegal_out       one-cycle pulse for a squashed illegal encoding
//   squash_cnt        saturating count of squashed valid instructions
module arm_id_ctrl_stage #(
    parameter int PC_W          = 32,
    parameter int BRANCH_SHADOW = 2,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic [3:0]       cond,
    input  logic [1:0]       mode,
    input  logic [3:0]       op_code,
    input  logic             s,
    input  logic [3:0]       nzcv,
    input  logic [PC_W-1:0]  pc_in,
    input  logic             stall,
    input  logic             flush,
    output logic             valid_out,
    output logic             wb_en_out,
    output logic             mem_read_out,
    output logic             mem_write_out,
    output logic [3:0]       exe_cmd_out,
    output logic             b_out,
    output logic             s_out,
    output logic [PC_W-1:0]  pc_out,
    output logic             illegal_out,
    output logic [CNT_W-1:0] squash_cnt
);

    localparam int SH_W = (BRANCH_SHADOW > 0) ?
                          $clog2(BRANCH_SHADOW + 1) : 1;
    localparam logic [SH_W-1:0] SH_LOAD = SH_W'(BRANCH_SHADOW);

    logic            dec_wb;
    logic            dec_mr;
    logic            dec_mw;
    logic [3:0]      dec_cmd;
    logic            dec_b;
    logic            dec_s;
    logic            dec_ill;
    logic            cond_ok;
    logic            squash;
    logic            shadow_busy;
    logic [SH_W-1:0] shadow;

    always_comb begin
        dec_wb  = 1'b0;
        dec_mr  = 1'b0;
        dec_mw  = 1'b0;
        dec_cmd = 4'b0000;
        dec_b   = 1'b0;
        dec_s   = 1'b0;
        dec_ill = 1'b0;
        case (mode)
            2'b00: begin
                dec_wb = 1'b1;
                dec_s  = s;
                case (op_code)
                    4'b1101: dec_cmd = 4'b0001;
                    4'b1111: dec_cmd = 4'b1001;
                    4'b0100: dec_cmd = 4'b0010;
                    4'b0101: dec_cmd = 4'b0011;
                    4'b0010: dec_cmd = 4'b0100;
                    4'b0110: dec_cmd = 4'b0101;
                    4'b0000: dec_cmd = 4'b0110;
                    4'b1100: dec_cmd = 4'b0111;
                    4'b0001: dec_cmd = 4'b1000;
                    4'b1010: begin
                        dec_wb  = 1'b0;
                        dec_cmd = 4'b0100;
                    end
                    4'b1000: begin
                        dec_wb  = 1'b0;
                        dec_cmd = 4'b0110;
                    end
                    default: begin
                        dec_wb  = 1'b0;
                        dec_s   = 1'b0;
                        dec_ill = 1'b1;
                    end
                endcase
            end
            2'b01: begin
                dec_cmd = 4'b0010;
                dec_wb  = s;
                dec_mr  = s;
                dec_mw  = ~s;
            end
            2'b10: dec_b = 1'b1;
            default: dec_ill = 1'b1;
        endcase
    end

    // nzcv = {N,Z,C,V}
    always_comb begin
        cond_ok = 1'b0;
        case (cond)
            4'b0000: cond_ok = nzcv[2];
            4'b0001: cond_ok = ~nzcv[2];
            4'b0010: cond_ok = nzcv[1];
            4'b0011: cond_ok = ~nzcv[1];
            4'b0100: cond_ok = nzcv[3];
            4'b0101: cond_ok = ~nzcv[3];
            4'b0110: cond_ok = nzcv[0];
            4'b0111: cond_ok = ~nzcv[0];
            4'b1000: cond_ok = nzcv[1] & ~nzcv[2];
            4'b1001: cond_ok = ~nzcv[1] | nzcv[2];
            4'b1010: cond_ok = nzcv[3] == nzcv[0];
            4'b1011: cond_ok = nzcv[3] != nzcv[0];
            4'b1100: cond_ok = ~nzcv[2] & (nzcv[3] == nzcv[0]);
            4'b1101: cond_ok = nzcv[2] | (nzcv[3] != nzcv[0]);
            4'b1110: cond_ok = 1'b1;
            default: cond_ok = 1'b0;
        endcase
    end

    assign shadow_busy = shadow != '0;
    assign squash = ~valid_in | ~cond_ok | shadow_busy | dec_ill;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_out     <= 1'b0;
            wb_en_out     <= 1'b0;
            mem_read_out  <= 1'b0;
            mem_write_out <= 1'b0;
            exe_cmd_out   <= 4'b0000;
            b_out         <= 1'b0;
            s_out         <= 1'b0;
            pc_out        <= '0;
            illegal_out   <= 1'b0;
            squash_cnt    <= '0;
            shadow        <= '0;
        end else if (flush) begin
            valid_out     <= 1'b0;
            wb_en_out     <= 1'b0;
            mem_read_out  <= 1'b0;
            mem_write_out <= 1'b0;
            exe_cmd_out   <= 4'b0000;
            b_out         <= 1'b0;
            s_out         <= 1'b0;
            pc_out        <= pc_in;
            illegal_out   <= 1'b0;
            shadow        <= '0;
        end else if (stall) begin
            illegal_out   <= 1'b0;
        end else begin
            valid_out     <= ~squash;
            wb_en_out     <= dec_wb & ~squash;
            mem_read_out  <= dec_mr & ~squash;
            mem_write_out <= dec_mw & ~squash;
            exe_cmd_out   <= squash ? 4'b0000 : dec_cmd;
            b_out         <= dec_b & ~squash;
            s_out         <= dec_s & ~squash;
            pc_out        <= pc_in;
            illegal_out   <= valid_in & cond_ok & dec_ill;
            // A squashed branch never reloads the shadow.
            if (dec_b && !squash)
                shadow <= SH_LOAD;
            else if (shadow_busy && valid_in)
                shadow <= shadow - SH_W'(1);
            if (valid_in && squash && squash_cnt != '1)
                squash_cnt <= squash_cnt + CNT_W'(1);
        end
    end

endmodule
